// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port memory between instruction fetch (requester 0) and
// load/store (requester 1). One request is accepted at a time. The winner's
// command is latched, driven onto the memory port for one strobe cycle, and
// the fixed memory latency is counted out. Read data or a write acknowledge
// is then returned to the winner.
//
// Handshake: a requester holds reqN and its command (weN/addrN/wdataN)
// stable until it sees gntN, and may drop req from the gnt cycle onward.
// Requests are only sampled in IDLE. rvalidN is a one-cycle completion pulse.
// rdata is shared and qualified by rvalid0/rvalid1.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   req0/1, we0/1          request and write flag per requester
//   addr0/1, wdata0/1      request address and write data per requester
//   gnt0/1                 one-cycle grant pulse (ACCESS cycle)
//   rvalid0/1, rdata       one-cycle completion pulse, shared read data
//   mem_en, mem_we         memory strobe (ACCESS only) and write enable
//   mem_addr, mem_wdata    memory address / write data from command regs
//   mem_rdata              memory read data, valid MEM_LATENCY cycles after mem_en
//   mem_sel                datapath mux select (0 = requester 0, 1 = requester 1)
//   busy                   high in every state except IDLE
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_sel,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [3:0] LAT_M1    = 4'(MEM_LATENCY - 1);
  localparam bit         SKIP_WAIT = (MEM_LATENCY == 1);

  state_t                  state_q, state_d;
  logic                    last_q;      // requester granted most recently
  logic                    win_q;       // winner of the current transaction
  logic                    win_d;
  logic                    cmd_we_q;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q;
  logic [DATA_WIDTH-1:0]   cmd_wdata_q;
  logic [3:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    take;        // a request is accepted this cycle
  logic                    capture;     // mem_rdata is valid this cycle

  // On a tie the requester that was not granted last wins.
  assign win_d = (req0 && req1) ? ~last_q : req1;
  assign take  = (state_q == IDLE) && (req0 || req1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    rvalid0 = 1'b0;
    rvalid1 = 1'b0;
    mem_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) state_d = ACCESS;
      end
      ACCESS: begin
        gnt0   = ~win_q;
        gnt1   = win_q;
        mem_en = 1'b1;
        cnt_d  = LAT_M1;
        // With a one-cycle memory the data is already valid in the strobe cycle.
        if (SKIP_WAIT) begin
          capture = ~cmd_we_q;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // cnt_q holds the cycles left until mem_rdata is valid; the last
        // WAIT cycle is the one where it reaches 1, and the decrement that
        // takes it to 0 coincides with the capture edge.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          capture = ~cmd_we_q;
          state_d = RESP;
        end
      end
      RESP: begin
        rvalid0 = ~win_q;
        rvalid1 = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cnt_q       <= 4'd0;
      rdata_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        win_q       <= win_d;
        last_q      <= win_d;
        cmd_we_q    <= win_d ? we1 : we0;
        cmd_addr_q  <= win_d ? addr1 : addr0;
        cmd_wdata_q <= win_d ? wdata1 : wdata0;
      end
      if (capture) rdata_q <= mem_rdata;
    end
  end

  // The write enable is only asserted while the command is on the port, so a
  // finished write never leaves mem_we high in IDLE.
  assign mem_we    = cmd_we_q && ((state_q == ACCESS) || (state_q == WAIT));
  assign mem_addr  = cmd_addr_q;
  assign mem_wdata = cmd_wdata_q;
  assign mem_sel   = win_q;
  assign busy      = (state_q != IDLE);
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. Three instances share the request inputs:
// index 0 uses MEM_LATENCY=2 and is checked by the scoreboard monitor,
// indices 1 and 2 use MEM_LATENCY=1 and 15 for the latency sweep. Each has a
// memory model that returns ~addr exactly MEM_LATENCY cycles after mem_en.
module tb_mem_port_arbiter;

  localparam int EW = 130;  // {id, we, addr, wdata, rdata, sample_cycle}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;

  logic        gnt0_w[3], gnt1_w[3], rvalid0_w[3], rvalid1_w[3];
  logic        mem_en_w[3], mem_we_w[3], mem_sel_w[3], busy_w[3];
  logic [31:0] rdata_w[3], mem_addr_w[3], mem_wdata_w[3], mem_rdata_w[3];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [EW-1:0] exp_q[$];
  logic        last_win = 1'b1;
  logic [31:0] cur_rd = '0;

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [31:0] a0, a1, d0, d1;
    logic        win;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl[7];

  // ---------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------------------------------------------------------- DUTs + memories
  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    logic [31:0] m_addr = '0;
    int          age = 0;
    always @(posedge clk) begin
      if (mem_en_w[g]) begin
        m_addr <= mem_addr_w[g];
        age    <= 1;
      end else if (age != 0) begin
        age <= age + 1;
      end
    end
    if (LAT == 1) begin : g_comb
      assign mem_rdata_w[g] = mem_en_w[g] ? ~mem_addr_w[g] : 32'hA5A5_A5A5;
    end else begin : g_reg
      assign mem_rdata_w[g] = (age == LAT - 1) ? ~m_addr : 32'hA5A5_A5A5;
    end
    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0_w[g]), .gnt1(gnt1_w[g]),
      .rvalid0(rvalid0_w[g]), .rvalid1(rvalid1_w[g]), .rdata(rdata_w[g]),
      .mem_en(mem_en_w[g]), .mem_we(mem_we_w[g]),
      .mem_addr(mem_addr_w[g]), .mem_wdata(mem_wdata_w[g]),
      .mem_rdata(mem_rdata_w[g]), .mem_sel(mem_sel_w[g]), .busy(busy_w[g])
    );
  end

  // ---------------------------------------------------------------- scoreboard
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  // A reset drops whatever transaction was outstanding.
  always @(posedge clk) if (!rst_n) exp_q.delete();

  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    chk("invariant",
        {60'd0, mem_en_w[0], gnt0_w[0] & gnt1_w[0], rvalid0_w[0] & rvalid1_w[0],
         (gnt0_w[0] & rvalid0_w[0]) | (gnt1_w[0] & rvalid1_w[0])},
        {60'd0, gnt0_w[0] | gnt1_w[0], 3'b000});
    if (gnt0_w[0] || gnt1_w[0]) begin
      chk("gnt_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("gnt_id", {gnt1_w[0], gnt0_w[0]}, {e[129], ~e[129]});
        chk("gnt_cycle", cyc, e[31:0]);
        chk("mem_sel", mem_sel_w[0], e[129]);
        chk("mem_we", mem_we_w[0], e[128]);
        chk("mem_addr", mem_addr_w[0], e[127:96]);
        chk("mem_wdata", mem_wdata_w[0], e[95:64]);
      end
    end
    if (rvalid0_w[0] || rvalid1_w[0]) begin
      chk("rvalid_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rvalid_id", {rvalid1_w[0], rvalid0_w[0]}, {e[129], ~e[129]});
        chk("rvalid_cycle", cyc, e[31:0] + 32'd2);
        chk("rdata", rdata_w[0], e[63:32]);
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy_w[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", busy_w[0], 0);
  endtask

  // Drives one request set at a negedge while idle (or while releasing reset),
  // pushes the expected transaction and waits for its grant. Only the
  // winner drops its request; a losing requester keeps its command pending.
  task automatic issue(input logic from_rst, input logic r0, input logic r1,
                       input logic w0, input logic w1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic win, input logic [31:0] rd, output int e_cyc);
    int n;
    if (!from_rst) wait_idle();
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    rst_n = 1'b1;
    e_cyc = cyc + 1;
    exp_q.push_back({win, win ? w1 : w0, win ? a1 : a0, win ? d1 : d0, rd, 32'(e_cyc)});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(gnt0_w[0] || gnt1_w[0]) && n < 4);
    chk("gnt_seen", gnt0_w[0] | gnt1_w[0], 1);
    if (win) req1 = 1'b0;
    else     req0 = 1'b0;
    last_win = win;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int          e, c1, c2, n_rv;
    logic [31:0] rd1, rd2;
    logic        p0, p1, r0, r1, win, ww;
    logic        nw0, nw1;
    logic [31:0] na0, na1, nd0, nd1, aw, rd;

    // Both requesters pending on independent commands; a tie resolves against
    // the last grant, and every loser is re-presented with the same command.
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h200, 32'h0,         32'h0,         1'b1, 32'hFFFF_FDFF};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0,   32'h0,         32'h0,         1'b0, 32'hFFFF_FFEF};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  32'h20,  32'h0,         32'hDEAD_BEEF, 1'b1, 32'hFFFF_FFEF};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h44, 32'h80,  32'h1234_5678, 32'h0,         1'b0, 32'hFFFF_FFEF};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h8,  32'h80,  32'h0,         32'h0,         1'b1, 32'hFFFF_FF7F};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h8,  32'hC,   32'h0,         32'hCAFE_F00D, 1'b0, 32'hFFFF_FFF7};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  32'hC,   32'h0,         32'hCAFE_F00D, 1'b1, 32'hFFFF_FFF7};

    // Reset held 3 cycles with both requests high: everything stays at 0.
    req0 = 1'b1; req1 = 1'b1; addr0 = 32'h100; addr1 = 32'h200;
    repeat (3) begin
      @(negedge clk);
      chk("reset_ctrl", {gnt0_w[0], gnt1_w[0], rvalid0_w[0], rvalid1_w[0], mem_en_w[0],
                         mem_we_w[0], mem_sel_w[0], busy_w[0]}, 0);
      chk("reset_data", {mem_addr_w[0], mem_wdata_w[0]}, 0);
      chk("reset_rdata", rdata_w[0], 0);
    end
    // Release: the pointer resets to 1, so requester 0 wins the first tie.
    issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h200, 32'h0, 32'h0, 1'b0, 32'hFFFF_FEFF, e);

    foreach (tbl[i])
      issue(1'b0, tbl[i].r0, tbl[i].r1, tbl[i].w0, tbl[i].w1, tbl[i].a0, tbl[i].a1,
            tbl[i].d0, tbl[i].d1, tbl[i].win, tbl[i].rd, e);

    // Contention: both held for four transactions, grants 0,1,0,1 spaced 4 cycles.
    wait_idle();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h300; wdata0 = 32'h0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h400; wdata1 = 32'h0;
    e = cyc + 1;
    for (int k = 0; k < 4; k++)
      exp_q.push_back({k[0], 1'b0, k[0] ? 32'h400 : 32'h300, 32'h0,
                       k[0] ? 32'hFFFF_FBFF : 32'hFFFF_FCFF, 32'(e + 4 * k)});
    repeat (15) @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    last_win = 1'b1;
    cur_rd = 32'hFFFF_FBFF;

    // Random singles and ties; a loser stays pending with the same command.
    p0 = 1'b0; p1 = 1'b0;
    nw0 = 1'b0; nw1 = 1'b0; na0 = '0; na1 = '0; nd0 = '0; nd1 = '0;
    for (int k = 0; k < 10 || p0 || p1; k++) begin
      if (!p0) begin nw0 = 1'($urandom_range(0, 1)); na0 = $urandom; nd0 = $urandom; end
      if (!p1) begin nw1 = 1'($urandom_range(0, 1)); na1 = $urandom; nd1 = $urandom; end
      r0 = p0 ? 1'b1 : ((k < 10) ? 1'($urandom_range(0, 1)) : 1'b0);
      r1 = p1 ? 1'b1 : ((k < 10) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (!r0 && !r1) r0 = 1'b1;
      win = (r0 && r1) ? ~last_win : r1;
      ww  = win ? nw1 : nw0;
      aw  = win ? na1 : na0;
      rd  = ww ? cur_rd : ~aw;
      cur_rd = rd;
      issue(1'b0, r0, r1, nw0, nw1, na0, na1, nd0, nd1, win, rd, e);
      p0 = r0 && win;
      p1 = r1 && !win;
    end

    // Latency sweep: fresh reset, one read seen by all three latencies.
    wait_idle();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    cur_rd = '0;
    issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h55, 32'h0, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFAA, e);
    chk("sweep_gnt_lat1", gnt0_w[1], 1);
    chk("sweep_gnt_lat15", gnt0_w[2], 1);
    c1 = -1; c2 = -1; rd1 = '0; rd2 = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rvalid0_w[1] && c1 < 0) begin c1 = cyc; rd1 = rdata_w[1]; end
      if (rvalid0_w[2] && c2 < 0) begin c2 = cyc; rd2 = rdata_w[2]; end
    end
    chk("lat1_rvalid_cycle", 64'(c1), 64'(e + 1));
    chk("lat15_rvalid_cycle", 64'(c2), 64'(e + 15));
    chk("lat1_rdata", rd1, 32'hFFFF_FFAA);
    chk("lat15_rdata", rd2, 32'hFFFF_FFAA);

    // Reset during WAIT of a requester 0 read: no rvalid, pointer back to 1.
    issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h66, 32'h0, 32'h0, 32'h0, 1'b0, 32'hFFFF_FF99, e);
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h70;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h74;
    n_rv = 0;
    repeat (2) begin
      @(negedge clk);
      if (rvalid0_w[0] || rvalid1_w[0]) n_rv++;
    end
    chk("no_rvalid_after_reset", 64'(n_rv), 0);
    chk("rdata_after_reset", rdata_w[0], 0);
    chk("busy_after_reset", busy_w[0], 0);
    // With the pointer reset to 1, requester 0 takes the first tie, then the
    // pending requester 1.
    issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h70, 32'h74, 32'h0, 32'h0, 1'b0, 32'hFFFF_FF8F, e);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h70, 32'h74, 32'h0, 32'h0, 1'b1, 32'hFFFF_FF8B, e);

    wait_idle();
    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
